cordic_fixedpoint_last_rotation_checker_pipe: RTL and testbench
===============================================================

CORDIC_FIXEDPOINT_LAST_ROTATION_CHECKER_PIPE -- requirements
Module: cordic_fixedpoint_last_rotation_checker_pipe

Interface
REQ-001 SHALL have parameter PHASE_W, default 21, meaning the unsigned width of the absolute phase.
REQ-002 SHALL have parameter NUM_WIN, default 16, meaning the number of threshold windows (range 2..32).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the hit-counter width.
REQ-004 SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port iRst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port iValid, input, 1 bit: iPhase_abs is valid.
REQ-007 SHALL have port oReady, output, 1 bit: the block accepts the input this cycle.
REQ-008 SHALL have port iPhase_abs, input, PHASE_W bits: the absolute phase, unsigned.
REQ-009 SHALL have port iTbl_we, input, 1 bit: threshold-table write strobe.
REQ-010 SHALL have port iTbl_sel, input, 1 bit: selects the table to write; 0 = sub table, 1 = add table.
REQ-011 SHALL have port iTbl_addr, input, $clog2(NUM_WIN) bits: window index to write.
REQ-012 SHALL have port iTbl_data, input, PHASE_W bits: threshold value to write.
REQ-013 SHALL have port oValid, output, 1 bit: the result is valid.
REQ-014 SHALL have port iReady, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port oPhase_check_last_rotation, output, 2 bits: bit0 = window hit; bit1 = near-zero flag.
REQ-016 SHALL have port iCnt_clr, input, 1 bit: synchronous clear of the hit counter.
REQ-017 SHALL have port oHit_cnt, output, CNT_W bits: saturating count of delivered results with bit0 = 1.

Function
REQ-018 SHALL hold the two tables, sub[0..NUM_WIN-1] and add[0..NUM_WIN-1], in registers that are run-time writable; the block SHALL NOT use file-initialised ROMs.
REQ-019 SHALL write iTbl_data into the table and index selected by iTbl_sel/iTbl_addr on an edge where iTbl_we=1; writes with iTbl_addr >= NUM_WIN SHALL be ignored.
REQ-020 SHALL evaluate the hit vector against the table contents before the edge, so a write in the same cycle as an accept affects only later accepts.
REQ-021 SHALL form the hit vector as follows:
- hit[0] = (phase >= sub[0]);
- hit[k] = (sub[k] <= phase <= add[k]) for k = 1..NUM_WIN-2;
- hit[NUM_WIN-1] = (sub[NUM_WIN-1] < phase <= add[NUM_WIN-1]), a strict lower bound.
REQ-022 SHALL compute near = (phase <= add[0]).
REQ-023 SHALL use a 2-stage pipeline: stage 1 registers hit[NUM_WIN-1:0] and near; stage 2 registers bit0 = OR-reduce(hit) and bit1 = near.
REQ-024 SHALL use global enable en = !oValid || iReady; oReady SHALL equal en.
REQ-025 SHALL accept an input when iValid && oReady.
REQ-026 SHALL advance both stages only when en=1, and stage-1 valid SHALL be loaded from the accept.
REQ-027 SHALL have a latency of 2 cycles from accept to oValid when unstalled, and sustain throughput of 1 result per cycle.
REQ-028 SHALL hold oValid and the output data stable while oValid && !iReady, with no result lost or duplicated.
REQ-029 SHALL increment oHit_cnt on each delivered result (oValid && iReady) with bit0=1, saturating at 2^CNT_W-1.
REQ-030 SHALL give iCnt_clr priority over a simultaneous increment, with the counter reading 0 on the next cycle.
REQ-031 SHALL produce identical hit values for phases 0 and 2^PHASE_W-1 regardless of comparison direction, with no overflow or wrap.

Reset
REQ-032 SHALL, while iRst_n=0 at an edge, clear both stage valids, oValid, oPhase_check_last_rotation and oHit_cnt to 0.
REQ-033 SHALL, on the same reset, set sub[] to all-ones and add[] to all-zeros.
REQ-034 SHALL ignore table writes during reset and discard in-flight results on a mid-operation reset.
REQ-035 SHALL drive oReady to 1 in the first cycle after reset release.

Configuration
REQ-036 SHALL, with CORDIC_LRC_INDEX_OUT_EN defined, add output oHit_idx [$clog2(NUM_WIN)-1:0]: the lowest index k with hit[k]=1, 0 if none, pipelined alongside bit0.
REQ-037 SHALL, without CORDIC_LRC_INDEX_OUT_EN, have no such port and no priority encoder.

Structure
REQ-038 SHALL place default parameter constants, the table-select encoding (SEL_SUB=0, SEL_ADD=1) and the result-bit positions in package cordic_fixedpoint_pkg.
REQ-039 SHALL instantiate one sub-module, cordic_fixedpoint_window_cmp: a single-window combinational compare with parameter STRICT_LO, instantiated NUM_WIN times.

Verification
REQ-040 SHALL be verified by: reset, no writes; phase=0 -> after 2 cycles, oPhase_check_last_rotation=2'b10; phase=2^21-1 -> 2'b01.
REQ-041 SHALL be verified by: sub[3]=100, add[3]=200, all others left at reset values; phases 99, 100, 200 and 201 -> bit0 = 0, 1, 1, 0.
REQ-042 SHALL be verified by: sub[15]=500, add[15]=600; phase 500 -> bit0=0; phase 501 -> bit0=1.
REQ-043 SHALL be verified by: a 4-sample back-to-back burst with iReady held low 3 cycles mid-burst -> 4 results delivered in order, outputs stable during the stall, oReady=0 while stalled.
REQ-044 SHALL be verified by: CNT_W=4 with 20 hits delivered -> oHit_cnt=15; then iCnt_clr coincident with a hit -> oHit_cnt=0.
REQ-045 SHALL be verified by: iRst_n pulled low with 2 results in flight -> oValid=0 on the next cycle and tables restored to reset values.

Source files
------------

// File: rtl/cordic_fixedpoint_pkg.sv
// Shared constants for the CORDIC last-rotation phase checker: default sizes,
// table-select encoding and result-bit positions.
package cordic_fixedpoint_pkg;

  localparam int unsigned PHASE_W_DEF = 21;
  localparam int unsigned NUM_WIN_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic {
    SEL_SUB = 1'b0,
    SEL_ADD = 1'b1
  } tbl_sel_e;

  localparam int unsigned RES_HIT_BIT  = 0;
  localparam int unsigned RES_NEAR_BIT = 1;

endpackage

// File: rtl/cordic_fixedpoint_window_cmp.sv
// Single threshold window compare: lo <= phase (or lo < phase when STRICT_LO)
// and, when HAS_HI, phase <= hi. Purely combinational.
module cordic_fixedpoint_window_cmp
  import cordic_fixedpoint_pkg::*;
#(
  parameter int unsigned PHASE_W   = PHASE_W_DEF,
  parameter bit          STRICT_LO = 1'b0,
  parameter bit          HAS_HI    = 1'b1
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] lo,
  input  logic [PHASE_W-1:0] hi,
  output logic               hit_c
);

  logic lo_ok;
  logic hi_ok;

  // Unsigned compares of equal width: the phase extremes never wrap.
  always_comb begin
    lo_ok = STRICT_LO ? (phase > lo) : (phase >= lo);
    hi_ok = HAS_HI ? (phase <= hi) : 1'b1;
    hit_c = lo_ok & hi_ok;
  end

endmodule

// File: rtl/cordic_fixedpoint_last_rotation_checker_pipe.sv
// Two-stage pipelined phase window checker with run-time writable threshold
// tables and a saturating hit counter. Define CORDIC_LRC_INDEX_OUT_EN to add oHit_idx.
module cordic_fixedpoint_last_rotation_checker_pipe
  import cordic_fixedpoint_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned NUM_WIN = NUM_WIN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  localparam int unsigned AW     = $clog2(NUM_WIN)
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iValid,
  output logic               oReady,
  input  logic [PHASE_W-1:0] iPhase_abs,
  input  logic               iTbl_we,
  input  logic               iTbl_sel,
  input  logic [AW-1:0]      iTbl_addr,
  input  logic [PHASE_W-1:0] iTbl_data,
  output logic               oValid,
  input  logic               iReady,
  output logic [1:0]         oPhase_check_last_rotation,
  input  logic               iCnt_clr,
  output logic [CNT_W-1:0]   oHit_cnt
`ifdef CORDIC_LRC_INDEX_OUT_EN
  ,
  output logic [AW-1:0]      oHit_idx
`endif
);

  logic [PHASE_W-1:0] sub_q [NUM_WIN];
  logic [PHASE_W-1:0] sub_d [NUM_WIN];
  logic [PHASE_W-1:0] add_q [NUM_WIN];
  logic [PHASE_W-1:0] add_d [NUM_WIN];

  logic [NUM_WIN-1:0] hit_c;
  logic               near_c;
  logic               en_c;

  logic               s1_valid_q, s1_valid_d;
  logic [NUM_WIN-1:0] s1_hit_q, s1_hit_d;
  logic               s1_near_q, s1_near_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_res_q, out_res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Table writes; addresses beyond the last window match no entry.
  always_comb begin
    sub_d = sub_q;
    add_d = add_q;
    if (iTbl_we) begin
      for (int k = 0; k < NUM_WIN; k++) begin
        if (iTbl_addr == AW'(k)) begin
          if (tbl_sel_e'(iTbl_sel) == SEL_ADD) add_d[k] = iTbl_data;
          else                                 sub_d[k] = iTbl_data;
        end
      end
    end
  end

  // Window 0 has no upper bound; the last window has a strict lower bound.
  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    cordic_fixedpoint_window_cmp #(
      .PHASE_W  (PHASE_W),
      .STRICT_LO(k == NUM_WIN - 1),
      .HAS_HI   (k != 0)
    ) u_cmp (
      .phase(iPhase_abs),
      .lo   (sub_q[k]),
      .hi   (add_q[k]),
      .hit_c(hit_c[k])
    );
  end

  assign near_c = (iPhase_abs <= add_q[0]);

  // Pipeline advance and hit counter; iCnt_clr wins over an increment.
  always_comb begin
    en_c        = !out_valid_q || iReady;
    s1_valid_d  = s1_valid_q;
    s1_hit_d    = s1_hit_q;
    s1_near_d   = s1_near_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    cnt_d       = cnt_q;
    if (en_c) begin
      s1_valid_d              = iValid;
      s1_hit_d                = hit_c;
      s1_near_d               = near_c;
      out_valid_d             = s1_valid_q;
      out_res_d[RES_HIT_BIT]  = |s1_hit_q;
      out_res_d[RES_NEAR_BIT] = s1_near_q;
    end
    if (iCnt_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && iReady && out_res_q[RES_HIT_BIT] && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sub_q       <= '{default: '1};
      add_q       <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      s1_near_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      cnt_q       <= '0;
    end else begin
      sub_q       <= sub_d;
      add_q       <= add_d;
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_near_q   <= s1_near_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oReady                     = en_c;
  assign oValid                     = out_valid_q;
  assign oPhase_check_last_rotation = out_res_q;
  assign oHit_cnt                   = cnt_q;

`ifdef CORDIC_LRC_INDEX_OUT_EN
  logic [AW-1:0] idx_c;
  logic [AW-1:0] idx_q, idx_d;

  // Lowest-index priority encode of the stage-1 hit vector.
  always_comb begin
    idx_c = '0;
    for (int k = NUM_WIN - 1; k >= 0; k--) begin
      if (s1_hit_q[k]) idx_c = AW'(k);
    end
    idx_d = en_c ? idx_c : idx_q;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) idx_q <= '0;
    else         idx_q <= idx_d;
  end

  assign oHit_idx = idx_q;
`endif

endmodule

// File: tb/tb_cordic_fixedpoint_last_rotation_checker_pipe.sv
// Self-checking bench: directed vector table, hand-written stall/counter/reset
// sequences and a randomized stream checked against a window-rule model.
module tb_cordic_fixedpoint_last_rotation_checker_pipe;
  import cordic_fixedpoint_pkg::*;

  localparam int unsigned PW   = 21;
  localparam int unsigned NW   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned AW   = $clog2(NW);
  localparam logic [PW-1:0] PMAX = {PW{1'b1}};
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, valid_i, ready_o, we, sel, valid_o, ready_i, clr;
  logic [PW-1:0] phase, tdata;
  logic [AW-1:0] taddr;
  logic [1:0]    res_o;
  logic [CW-1:0] cnt_o;
`ifdef CORDIC_LRC_INDEX_OUT_EN
  logic [AW-1:0] idx_o;
`endif

  always #5 clk = ~clk;

  cordic_fixedpoint_last_rotation_checker_pipe #(
    .PHASE_W(PW), .NUM_WIN(NW), .CNT_W(CW)
  ) dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid_i), .oReady(ready_o),
    .iPhase_abs(phase), .iTbl_we(we), .iTbl_sel(sel), .iTbl_addr(taddr),
    .iTbl_data(tdata), .oValid(valid_o), .iReady(ready_i),
    .oPhase_check_last_rotation(res_o), .iCnt_clr(clr), .oHit_cnt(cnt_o)
`ifdef CORDIC_LRC_INDEX_OUT_EN
    , .oHit_idx(idx_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct packed { logic [1:0] res; logic [AW-1:0] idx; } exp_t;
  logic [PW-1:0] sub_m [NW];
  logic [PW-1:0] add_m [NW];
  exp_t          exp_q [$];
  logic [PW-1:0] to_send [$];
  int            m_cnt;
  bit            stall_prev;
  logic [1:0]    held_res;
  bit            acc, dlv;
  logic [1:0]    dlv_res;
  int            n_dlv;

  function automatic exp_t ref_model(logic [PW-1:0] p);
    exp_t e;
    bit found;
    found = 1'b0;
    e.idx = '0;
    for (int k = 0; k < NW; k++) begin
      bit in_win;
      if (k == 0)           in_win = (p >= sub_m[k]);
      else if (k == NW - 1) in_win = (p > sub_m[k]) && (p <= add_m[k]);
      else                  in_win = (p >= sub_m[k]) && (p <= add_m[k]);
      if (in_win && !found) begin
        found = 1'b1;
        e.idx = AW'(k);
      end
    end
    e.res = {(p <= add_m[0]), found};
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NW; k++) begin
      sub_m[k] = PMAX;
      add_m[k] = '0;
    end
    exp_q.delete();
    m_cnt      = 0;
    stall_prev = 1'b0;
  endtask

  // One clock: entered and left just after a falling edge with inputs driven.
  task automatic cycle();
    exp_t e;
    #1;
    chk("oready_rule", int'(ready_o), int'(!valid_o || ready_i));
    if (stall_prev) begin
      chk("stall_valid", int'(valid_o), 1);
      chk("stall_data", int'(res_o), int'(held_res));
    end
    acc        = valid_i && ready_o;
    dlv        = valid_o && ready_i;
    stall_prev = valid_o && !ready_i;
    held_res   = res_o;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (dlv) begin
        n_dlv++;
        dlv_res = res_o;
        chk("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", int'(res_o), int'(e.res));
`ifdef CORDIC_LRC_INDEX_OUT_EN
          chk("hit_idx", int'(idx_o), int'(e.idx));
`endif
        end
      end
      if (acc) exp_q.push_back(ref_model(phase));
      if (we) begin
        if (sel) add_m[taddr] = tdata;
        else     sub_m[taddr] = tdata;
      end
      if (clr) m_cnt = 0;
      else if (dlv && res_o[0] && m_cnt < CMAX) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("hit_cnt", int'(cnt_o), m_cnt);
    if (!rst_n) begin
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_res", int'(res_o), 0);
    end
  endtask

  task automatic tbl_write(logic s, int a, int d);
    we = 1'b1; sel = s; taddr = AW'(a); tdata = PW'(d);
    valid_i = 1'b0; ready_i = 1'b1;
    cycle();
    we = 1'b0;
  endtask

  task automatic send_one(logic [PW-1:0] p, output logic [1:0] r);
    int budget;
    budget = 20;
    r = '0;
    n_dlv = 0;
    to_send.push_back(p);
    we = 1'b0; ready_i = 1'b1; phase = p;
    while (n_dlv == 0 && budget > 0) begin
      valid_i = (to_send.size() > 0);
      cycle();
      if (acc) void'(to_send.pop_front());
      if (dlv) r = dlv_res;
      budget--;
    end
    valid_i = 1'b0;
    chk("send_one_delivered", n_dlv, 1);
  endtask

  task automatic drain(int stall_at, int stall_len, bit rnd, int budget, output int used);
    used = 0;
    while ((to_send.size() > 0 || exp_q.size() > 0) && used < budget) begin
      valid_i = (to_send.size() > 0) && (!rnd || $urandom_range(3) != 0);
      phase   = (to_send.size() > 0) ? to_send[0] : '0;
      if (rnd) ready_i = ($urandom_range(2) != 0);
      else     ready_i = !(used >= stall_at && used < stall_at + stall_len);
      we    = rnd && ($urandom_range(3) == 0);
      sel   = 1'($urandom_range(1));
      taddr = AW'($urandom_range(NW - 1));
      tdata = PW'($urandom_range(1023));
      cycle();
      if (acc) void'(to_send.pop_front());
      used++;
    end
    chk("drain_done", to_send.size() + exp_q.size(), 0);
    valid_i = 1'b0; we = 1'b0; ready_i = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0]    pre;    // 1: program window 3, 2: program window 15
    logic [PW-1:0] phase;
    logic [1:0]    exp;
  } vec_t;

  initial begin
    vec_t       vecs [8];
    logic [1:0] r;
    int         used;

    vecs[0] = '{pre: 2'd0, phase: '0,       exp: 2'b10};
    vecs[1] = '{pre: 2'd0, phase: PMAX,     exp: 2'b01};
    vecs[2] = '{pre: 2'd1, phase: PW'(99),  exp: 2'b00};
    vecs[3] = '{pre: 2'd0, phase: PW'(100), exp: 2'b01};
    vecs[4] = '{pre: 2'd0, phase: PW'(200), exp: 2'b01};
    vecs[5] = '{pre: 2'd0, phase: PW'(201), exp: 2'b00};
    vecs[6] = '{pre: 2'd2, phase: PW'(500), exp: 2'b00};
    vecs[7] = '{pre: 2'd0, phase: PW'(501), exp: 2'b01};

    rst_n = 1'b0; valid_i = 1'b0; we = 1'b0; sel = 1'b0; taddr = '0;
    tdata = '0; phase = '0; ready_i = 1'b1; clr = 1'b0; n_dlv = 0;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_cnt", int'(cnt_o), 0);
    chk("reset_ready", int'(ready_o), 1);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre == 2'd1) begin
        tbl_write(SEL_SUB, 3, 100);
        tbl_write(SEL_ADD, 3, 200);
      end else if (vecs[i].pre == 2'd2) begin
        tbl_write(SEL_SUB, 15, 500);
        tbl_write(SEL_ADD, 15, 600);
      end
      send_one(vecs[i].phase, r);
      chk($sformatf("vec%0d", i), int'(r), int'(vecs[i].exp));
    end

    // Two-cycle latency
    valid_i = 1'b1; phase = PMAX; ready_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    chk("latency_c1_valid", int'(valid_o), 0);
    cycle();
    chk("latency_c2_valid", int'(valid_o), 1);
    cycle();

    // Full throughput: 6 samples in 8 cycles
    for (int i = 0; i < 6; i++) to_send.push_back(PW'(90 + 30 * i));
    n_dlv = 0;
    drain(1000, 0, 1'b0, 40, used);
    chk("throughput_cycles", used, 8);
    chk("throughput_count", n_dlv, 6);

    // Table write in the accept cycle only affects later accepts
    tbl_write(SEL_ADD, 5, 400);
    n_dlv = 0;
    valid_i = 1'b1; phase = PW'(300); ready_i = 1'b1;
    we = 1'b1; sel = SEL_SUB; taddr = AW'(5); tdata = PW'(250);
    cycle();
    valid_i = 1'b0; we = 1'b0;
    cycle();
    cycle();
    chk("same_cycle_dlv", n_dlv, 1);
    chk("same_cycle_write", int'(dlv_res), 0);
    send_one(PW'(300), r);
    chk("after_write", int'(r), 1);

    // Burst of 4 with a 3-cycle downstream stall
    to_send.push_back(PW'(150)); to_send.push_back(PW'(0));
    to_send.push_back(PMAX);     to_send.push_back(PW'(550));
    n_dlv = 0;
    drain(2, 3, 1'b0, 40, used);
    chk("burst_count", n_dlv, 4);

    // Saturating counter and clear priority
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("cnt_cleared", int'(cnt_o), 0);
    for (int i = 0; i < 20; i++) to_send.push_back(PMAX);
    drain(1000, 0, 1'b0, 60, used);
    chk("cnt_saturated", int'(cnt_o), 15);
    valid_i = 1'b1; phase = PMAX; ready_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    cycle();
    chk("clr_hit_pending", int'(valid_o && res_o[0]), 1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_priority", int'(cnt_o), 0);

    // Mid-operation reset with two results in flight
    valid_i = 1'b1; phase = PW'(150); ready_i = 1'b1;
    cycle();
    cycle();
    valid_i = 1'b0;
    rst_n = 1'b0; we = 1'b1; sel = SEL_SUB; taddr = '0; tdata = '0;
    cycle();
    rst_n = 1'b1; we = 1'b0;
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_ready", int'(ready_o), 1);
    send_one(PW'(150), r);
    chk("midrst_win3_gone", int'(r), 0);
    send_one(PW'(5), r);
    chk("midrst_write_ignored", int'(r), 0);
    send_one(PW'(0), r);
    chk("midrst_near", int'(r), 2);

    // Randomized stream with random table writes and back-pressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) to_send.push_back(PW'($urandom()));
      else                        to_send.push_back(PW'($urandom_range(1100)));
    end
    drain(0, 0, 1'b1, 4000, used);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
